// File: rtl/axi_pkg.sv
// Shared AXI read-side constants and the responder FSM state encoding.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam int         LEN_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/rd_skid_buffer.sv
// 2-entry fall-through buffer: an incoming word is presented the same cycle when empty.
// No input ready; the writer meters pops against o_occ so a full buffer is never written.
module rd_skid_buffer #(
    parameter int WIDTH = 9
) (
    input  logic             i_aclk,
    input  logic             i_areset_n,
    input  logic             i_in_vld,
    input  logic [WIDTH-1:0] i_in_dat,
    output logic             o_out_vld,
    input  logic             i_out_rdy,
    output logic [WIDTH-1:0] o_out_dat,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    assign w_empty   = (r_cnt == 2'd0);
    assign o_out_vld = !w_empty || i_in_vld;
    assign o_out_dat = !w_empty ? r_mem[r_rd_ptr] : (i_in_vld ? i_in_dat : '0);
    assign o_occ     = r_cnt;

    // A word arriving into an empty buffer and taken at once never needs storing.
    assign w_wr = i_in_vld && !(w_empty && i_out_rdy);
    assign w_rd = i_out_rdy && !w_empty;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_in_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= r_cnt + {1'b0, w_wr} - {1'b0, w_rd};
        end
    end

endmodule

// File: rtl/axi_read_responder.sv
// AXI read responder: streams ARLEN+1 words from a 1-cycle-latency FIFO onto the R channel.
// First beat 2 cycles after AR handshake; RREADY backpressure throttles pops via a 2-deep credit.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET_N,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [LEN_WIDTH-1:0]  ARLEN,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  FIFO_RD_EN,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    input  logic                  FIFO_EMPTY
);

    localparam int CW = LEN_WIDTH + 1;

    rd_state_t       r_state;
    rd_state_t       w_state_nxt;
    logic [CW-1:0]   r_req_left;
    logic [CW-1:0]   r_beat_left;
    logic            r_pop_inflight;
    logic            r_pop_last;
    logic            w_arready;
    logic            w_ar_hs;
    logic            w_rd_en;
    logic            w_beat_acc;
    logic            w_out_vld;
    logic [DATA_WIDTH:0] w_out_dat;
    logic [1:0]      w_buf_occ;
    logic [2:0]      w_occ_net;

    assign w_beat_acc = w_out_vld && RREADY;
    assign w_ar_hs    = ARVALID && w_arready;

    // Slots still committed after this cycle's accepted beat leaves; a beat implies occ >= 1.
    assign w_occ_net = {1'b0, w_buf_occ} + {2'b00, r_pop_inflight} - {2'b00, w_beat_acc};

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arready   = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arready = ARESET_N;
                if (ARVALID && ARESET_N) begin
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                w_rd_en = (r_req_left != '0) && !FIFO_EMPTY && (w_occ_net < 3'd2);
                if (w_beat_acc && (r_beat_left == CW'(1))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            r_req_left     <= '0;
            r_beat_left    <= '0;
            r_pop_inflight <= 1'b0;
            r_pop_last     <= 1'b0;
        end else begin
            r_pop_inflight <= w_rd_en;
            r_pop_last     <= w_rd_en && (r_req_left == CW'(1));
            if (w_ar_hs) begin
                r_req_left  <= {1'b0, ARLEN} + CW'(1);
                r_beat_left <= {1'b0, ARLEN} + CW'(1);
            end else begin
                if (w_rd_en) begin
                    r_req_left <= r_req_left - CW'(1);
                end
                if (w_beat_acc) begin
                    r_beat_left <= r_beat_left - CW'(1);
                end
            end
        end
    end

    // The last flag travels with the word, so RLAST is tied to the data it belongs to.
    rd_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buf (
        .i_aclk     (ACLK),
        .i_areset_n (ARESET_N),
        .i_in_vld   (r_pop_inflight),
        .i_in_dat   ({r_pop_last, FIFO_DATA}),
        .o_out_vld  (w_out_vld),
        .i_out_rdy  (RREADY),
        .o_out_dat  (w_out_dat),
        .o_occ      (w_buf_occ)
    );

    assign ARREADY    = w_arready;
    assign FIFO_RD_EN = w_rd_en;
    assign RVALID     = w_out_vld;
    assign RDATA      = w_out_dat[DATA_WIDTH-1:0];
    assign RLAST      = w_out_dat[DATA_WIDTH];
    assign RRESP      = RESP_OKAY;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: FIFO model, expected-beat queue and a negedge monitor.
module tb_axi_read_responder;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          ACLK      = 1'b0;
    logic          ARESET_N  = 1'b0;
    logic          ARVALID   = 1'b0;
    logic          ARREADY;
    logic [LW-1:0] ARLEN     = '0;
    logic          RVALID;
    logic          RREADY    = 1'b0;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          FIFO_RD_EN;
    logic [DW-1:0] FIFO_DATA = '0;
    logic          FIFO_EMPTY;

    always #5 ACLK = ~ACLK;

    axi_read_responder #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .ACLK       (ACLK),
        .ARESET_N   (ARESET_N),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .ARLEN      (ARLEN),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RDATA      (RDATA),
        .RRESP      (RRESP),
        .RLAST      (RLAST),
        .FIFO_RD_EN (FIFO_RD_EN),
        .FIFO_DATA  (FIFO_DATA),
        .FIFO_EMPTY (FIFO_EMPTY)
    );

    // Source FIFO model: one-cycle read latency, flushed by system reset.
    logic [DW-1:0] fifo_mem [1024];
    int            fifo_wr = 0;
    int            fifo_rd = 0;
    int            pop_cnt = 0;

    assign FIFO_EMPTY = (fifo_rd == fifo_wr);

    always @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            fifo_rd <= fifo_wr;
        end else if (FIFO_RD_EN) begin
            FIFO_DATA <= fifo_mem[fifo_rd];
            fifo_rd   <= fifo_rd + 1;
            pop_cnt   <= pop_cnt + 1;
        end
    end

    logic [DW:0] exp_q [$];
    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          n_beats = 0;
    int          out_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat  = '0;
    logic [DW:0] mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: samples at negedge, far from the active edge.
    always @(negedge ACLK) begin
        if (!ARESET_N) begin
            chk("reset_outputs", 32'({ARREADY, RVALID, RLAST, FIFO_RD_EN, RRESP, RDATA}), 32'd0);
            exp_q.delete();
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", 32'({RVALID, RLAST, RDATA}), 32'({1'b1, prev_beat}));
            end
            if (FIFO_RD_EN) begin
                chk("rd_en_while_empty", 32'(FIFO_EMPTY), 32'd0);
            end
            if (RVALID && RREADY) begin
                n_beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_last_data", 32'({RLAST, RDATA}), 32'(mon_e));
                    chk("rresp_okay", 32'(RRESP), 32'd0);
                end
            end
            out_cnt = out_cnt + int'(FIFO_RD_EN) - int'(RVALID && RREADY);
            if (FIFO_RD_EN) begin
                chk("outstanding_le2", 32'(out_cnt <= 2), 32'd1);
            end
            prev_stall = RVALID && !RREADY;
            prev_beat  = {RLAST, RDATA};
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic last);
        fifo_mem[fifo_wr] = d;
        fifo_wr = fifo_wr + 1;
        exp_q.push_back({last, d});
    endtask

    // Request in the current cycle (N); checks pop at N+1 and first beat at N+2.
    task automatic issue_ar(input int len);
        ARVALID = 1'b1;
        ARLEN   = len[LW-1:0];
        @(negedge ACLK);
        chk("arready_at_request", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
        @(negedge ACLK);
        chk("rd_en_at_n_plus_1", 32'(FIFO_RD_EN), 32'd1);
        tick();
        @(negedge ACLK);
        chk("rvalid_at_n_plus_2", 32'(RVALID), 32'd1);
    endtask

    // Wait for return to IDLE; busy counts non-IDLE cycles after N+2.
    task automatic wait_idle(input int budget, input bit toggle, output int busy);
        bit done;
        done = 1'b0;
        busy = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (toggle) RREADY = ~RREADY;
            @(negedge ACLK);
            if (ARREADY) done = 1'b1;
            else busy++;
        end
        chk("burst_done_in_budget", 32'(done), 32'd1);
        RREADY = 1'b1;
    endtask

    int busy;
    int p0;
    int b0;

    initial begin
        repeat (3) tick();
        ARESET_N = 1'b1;
        RREADY   = 1'b1;

        // Four-beat burst at full rate
        tick();
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) push_word(8'(8'h11 + i), i == 3);
        issue_ar(3);
        wait_idle(20, 1'b0, busy);
        chk("t4beat_busy_cycles", 32'(busy), 32'd3);
        chk("t4beat_pops", 32'(pop_cnt - p0), 32'd4);

        // Single-beat burst
        tick();
        p0 = pop_cnt;
        push_word(8'hA5, 1'b1);
        issue_ar(0);
        wait_idle(10, 1'b0, busy);
        chk("t1beat_busy_cycles", 32'(busy), 32'd0);
        chk("t1beat_pops", 32'(pop_cnt - p0), 32'd1);

        // Eight beats with RREADY toggling every cycle
        tick();
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) push_word(8'(8'h21 + i), i == 7);
        issue_ar(7);
        wait_idle(60, 1'b1, busy);
        chk("ttoggle_busy_cycles", 32'(busy), 32'd14);
        chk("ttoggle_pops", 32'(pop_cnt - p0), 32'd8);

        // FIFO runs dry after two words, refilled later
        tick();
        p0 = pop_cnt;
        push_word(8'h51, 1'b0);
        push_word(8'h52, 1'b0);
        issue_ar(3);
        repeat (3) tick();
        @(negedge ACLK);
        chk("tdry_rvalid_low", 32'(RVALID), 32'd0);
        chk("tdry_pops_before_refill", 32'(pop_cnt - p0), 32'd2);
        repeat (3) tick();
        push_word(8'h53, 1'b0);
        push_word(8'h54, 1'b1);
        wait_idle(20, 1'b0, busy);
        chk("tdry_pops", 32'(pop_cnt - p0), 32'd4);

        // Reset mid-burst after two beats, then a fresh burst
        tick();
        b0 = n_beats;
        for (int i = 0; i < 4; i++) push_word(8'(8'h31 + i), i == 3);
        issue_ar(3);
        tick();
        tick();
        chk("treset_beats_before_reset", 32'(n_beats - b0), 32'd2);
        ARESET_N = 1'b0;
        tick();
        tick();
        ARESET_N = 1'b1;
        b0 = n_beats;
        push_word(8'h41, 1'b0);
        push_word(8'h42, 1'b1);
        issue_ar(1);
        wait_idle(10, 1'b0, busy);
        chk("treset_new_busy_cycles", 32'(busy), 32'd1);
        chk("treset_new_beats", 32'(n_beats - b0), 32'd2);

        // Maximum burst: 256 beats back to back
        tick();
        p0 = pop_cnt;
        for (int i = 0; i < 256; i++) push_word(8'(i * 3 + 1), i == 255);
        issue_ar(255);
        wait_idle(400, 1'b0, busy);
        chk("t256_busy_cycles", 32'(busy), 32'd255);
        chk("t256_pops", 32'(pop_cnt - p0), 32'd256);

        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of FIFO words and RDATA.
REQ-002 Parameter: LEN_WIDTH, 8, width of ARLEN (burst = ARLEN+1 beats, 1..256).
REQ-003 ACLK  input  1  clock; all logic on rising edge.
REQ-004 ARESET_N  input  1  reset, asynchronous, active-low.
REQ-005 ARVALID  input  1  read-address request valid.
REQ-006 ARREADY  output  1  responder accepts request.
REQ-007 ARLEN  input  LEN_WIDTH  burst length minus one.
REQ-008 RVALID  output  1  read-data beat valid.
REQ-009 RREADY  input  1  downstream accepts beat.
REQ-010 RDATA  output  DATA_WIDTH  beat data.
REQ-011 RRESP  output  2  response code.
REQ-012 RLAST  output  1  final beat of burst.
REQ-013 FIFO_RD_EN  output  1  pop request to source FIFO.
REQ-014 FIFO_DATA  input  DATA_WIDTH  FIFO read data, valid the cycle after FIFO_RD_EN.
REQ-015 FIFO_EMPTY  input  1  source FIFO empty flag.

Function
REQ-016 FSM states IDLE, BURST; IDLE after reset.
REQ-017 IDLE: ARREADY=1; on ARVALID&&ARREADY latch req_left=ARLEN+1 and beat_left=ARLEN+1 (LEN_WIDTH+1 bits, no overflow at ARLEN=255), go BURST.
REQ-018 BURST: ARREADY=0; ARVALID ignored.
REQ-019 Source FIFO read latency is fixed 1 cycle; FIFO_DATA captured unconditionally the cycle after FIFO_RD_EN.
REQ-020 Output held in 2-entry buffer; occ = buffered entries + in-flight pop (0..2).
REQ-021 FIFO_RD_EN = BURST && req_left!=0 && !FIFO_EMPTY && (occ - (RVALID&&RREADY)) < 2; req_left decrements on each pop.
REQ-022 FIFO_RD_EN never asserted while FIFO_EMPTY=1 or after req_left reaches 0.
REQ-023 RVALID=1 whenever buffer non-empty; RDATA = oldest entry; RDATA/RLAST stable while RVALID&&!RREADY.
REQ-024 Beat transfers on RVALID&&RREADY; beat_left decrements; RLAST=1 iff beat_left==1 on the presented beat.
REQ-025 RRESP = 2'b00 (OKAY) on every beat.
REQ-026 Latency: AR handshake cycle N, FIFO non-empty -> FIFO_RD_EN cycle N+1, RVALID cycle N+2.
REQ-027 Throughput: one beat per cycle sustained while FIFO non-empty and RREADY=1.
REQ-028 FIFO empty mid-burst: stall pops, drain buffered beats, resume on non-empty; no error response.
REQ-029 Simultaneous buffer write (FIFO data) and read (beat accepted) same cycle: occupancy unchanged, order preserved.
REQ-030 Transfer of RLAST beat -> IDLE next cycle; ARREADY=1 that cycle; back-to-back bursts gap is 1 cycle of ARREADY plus REQ-026 latency.
REQ-031 No data popped beyond ARLEN+1 per burst; buffer empty on return to IDLE.

Reset
REQ-032 ARESET_N low: state=IDLE, counters=0, buffer cleared, in-flight pop discarded, RVALID=0, RLAST=0, RDATA=0, RRESP=0, FIFO_RD_EN=0, ARREADY=0 while asserted.
REQ-033 Reset mid-burst abandons the burst; popped-but-unsent words are lost; ARREADY=1 first cycle after deassertion.

Structure
REQ-034 Shared package axi_pkg holds RESP_OKAY=2'b00, LEN_WIDTH default, and the IDLE/BURST state encoding.
REQ-035 One sub-module, rd_skid_buffer: 2-entry valid/ready buffer with occupancy output, parameterised on DATA_WIDTH+1 (data+last).
REQ-036 FSM, counters and pop-credit logic live in axi_read_responder.

Verification
REQ-037 FIFO preloaded 0x11..0x14, ARLEN=3, RREADY=1 -> RVALID at N+2, beats 0x11,0x12,0x13,0x14 on 4 consecutive cycles, RLAST only on 0x14, RRESP=0.
REQ-038 ARLEN=0, FIFO holds 0xA5 -> single beat 0xA5 with RLAST=1, IDLE next cycle, exactly one FIFO_RD_EN pulse.
REQ-039 ARLEN=7, RREADY toggled 1/0 every cycle -> 8 beats in order, RDATA stable during stalls, never >2 pops outstanding.
REQ-040 ARLEN=3, FIFO empty after 2 words, refilled 5 cycles later -> no FIFO_RD_EN while empty, RVALID drops, burst completes with correct RLAST.
REQ-041 ARESET_N pulsed low after 2 of 4 beats -> all outputs reset values, next ARVALID accepted cycle after deassertion, new burst starts cleanly.
REQ-042 ARLEN=255, FIFO always non-empty, RREADY=1 -> 256 beats on 256 consecutive cycles, RLAST on beat 256 only.
